// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Holds the FSM state encoding, the active-high hex glyphs and the all-off glyph.
// Glyph bit order is {A,B,C,D,E,F,G}, A in the MSB.
package sevenseg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
// Polarity and the decimal point are handled by the scan driver.
module sevenseg_hex_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  // Look up the glyph for the nibble
  always_comb begin
    glyph = SEG_OFF;
    case (hex)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 7-segment scan driver with PWM brightness, decimal points,
// per-frame snapshot of the displayed data and selectable output polarity.
// Optional leading-zero blanking is compiled in with SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int BLANK_SLOTS = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   sevenseg_control,
  output logic [0:7]              sevenseg_value,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0]  PRE_MAX    = '1;
  localparam logic [1:0]            LAST_BLANK = 2'((BLANK_SLOTS > 0) ? BLANK_SLOTS - 1 : 0);
  localparam logic                  POL        = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] CTRL_OFF   = {NUM_DIGITS{POL}};
  localparam logic [7:0]            VAL_OFF    = {8{POL}};

  logic [1:0]            state;
  logic [DIV_WIDTH-1:0]  prescaler;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            blank_cnt;
  logic [3:0]            snap_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  slot_end;
  logic                  advance;
  logic                  wrap;
  logic                  take_snap;
  logic [6:0]            glyph_raw;
  logic [NUM_DIGITS-1:0] ctrl_on;
  logic [7:0]            seg_on;

  // Slot boundaries and the digit-advance / frame-wrap conditions
  always_comb begin
    slot_end = (state != ST_IDLE) && (prescaler == PRE_MAX);
    if (BLANK_SLOTS == 0)
      advance = slot_end && (state == ST_SHOW);
    else
      advance = slot_end && (state == ST_BLANK) && (blank_cnt == LAST_BLANK);
    wrap      = advance && (idx == LAST_IDX);
    take_snap = enable && ((state == ST_IDLE) || wrap);
  end

  // Scan FSM: prescaler, digit index and blanking-slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prescaler <= '0;
      idx       <= '0;
      blank_cnt <= '0;
    end else if (!enable) begin
      state     <= ST_IDLE;
      prescaler <= '0;
      idx       <= '0;
      blank_cnt <= '0;
    end else if (state == ST_IDLE) begin
      state     <= ST_SHOW;
      prescaler <= '0;
      idx       <= '0;
      blank_cnt <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (slot_end) begin
        if ((state == ST_SHOW) && (BLANK_SLOTS > 0)) begin
          state     <= ST_BLANK;
          blank_cnt <= '0;
        end else if (advance) begin
          state     <= ST_SHOW;
          blank_cnt <= '0;
          idx       <= wrap ? '0 : idx + 1'b1;
        end else begin
          blank_cnt <= blank_cnt + 1'b1;
        end
      end
    end
  end

  // Capture digits and decimal points at the start of every frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_digit[i] <= '0;
      snap_dp <= '0;
    end else if (take_snap) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_digit[i] <= digits[4*i +: 4];
      snap_dp <= dp_mask;
    end
  end

  // Leading-zero mask over the snapshot; digit 0 always stays visible
  always_comb begin : lz_mask
    logic higher_zero;
    higher_zero = 1'b1;
    lz_blank    = '0;
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (snap_digit[i] == 4'h0);
      lz_blank[i] = higher_zero && (i != 0);
    end
`else
    lz_blank = '0;
`endif
  end

  sevenseg_hex_decoder u_decoder (
    .hex   (snap_digit[idx]),
    .glyph (glyph_raw)
  );

  // Active-high next values for the digit select and segment lines
  always_comb begin
    ctrl_on = '0;
    seg_on  = 8'h00;
    if (state == ST_SHOW) begin
      if (prescaler[DIV_WIDTH-1 -: 4] <= brightness) ctrl_on[idx] = 1'b1;
      seg_on = {(lz_blank[idx] ? SEG_OFF : glyph_raw), snap_dp[idx]};
    end
  end

  // Register outputs with board polarity applied, plus the frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sevenseg_control <= CTRL_OFF;
      sevenseg_value   <= VAL_OFF;
      frame_done       <= 1'b0;
    end else begin
      sevenseg_control <= ctrl_on ^ CTRL_OFF;
      sevenseg_value   <= seg_on ^ VAL_OFF;
      frame_done       <= enable && wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (4 digits, 16-clk slots,
// one blanking slot, common anode). Expected outputs come from a frame-position
// model: position within the frame determines digit, show/blank and PWM level.
module tb_sevenseg_scan_driver;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BS    = 1;
  localparam int AL    = 1;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = ND * (1 + BS) * SLOT;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    brightness = 4'd15;
  logic [3:0]    sevenseg_control;
  logic [0:7]    sevenseg_value;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;
  bit chk_en   = 1'b0;

  bit         m_run = 1'b0;
  int         m_pos = 0;
  logic [3:0] m_snap [ND];
  logic [3:0] m_dp = '0;
  logic [3:0] e_ctrl = 4'hF;
  logic [7:0] e_val = 8'hFF;
  logic       e_fd = 1'b0;

  sevenseg_scan_driver #(
    .NUM_DIGITS (ND),
    .DIV_WIDTH  (DW),
    .BLANK_SLOTS(BS),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .digits           (digits),
    .dp_mask          (dp_mask),
    .brightness       (brightness),
    .sevenseg_control (sevenseg_control),
    .sevenseg_value   (sevenseg_value),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] br, input logic en);
    digits     = d;
    dp_mask    = dp;
    brightness = br;
    enable     = en;
  endtask

  function automatic bit lzBlanked(int d);
    bit z;
    z = (d != 0);
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int j = d; j < ND; j++) if (m_snap[j] != 4'h0) z = 1'b0;
`else
    z = 1'b0;
`endif
    return z;
  endfunction

  // Expected registered outputs for the model's current frame position
  function automatic logic [3:0] modelCtrl();
    int slot, d, pre;
    logic [3:0] on;
    on = '0;
    if (m_run) begin
      slot = m_pos / SLOT;
      d    = slot / (1 + BS);
      pre  = m_pos % SLOT;
      if ((slot % (1 + BS)) == 0 && (pre >> (DW - 4)) <= int'(brightness)) on = 4'(1 << d);
    end
    return (AL != 0) ? ~on : on;
  endfunction

  function automatic logic [7:0] modelVal();
    int slot, d;
    logic [7:0] on;
    on = 8'h00;
    if (m_run) begin
      slot = m_pos / SLOT;
      d    = slot / (1 + BS);
      if ((slot % (1 + BS)) == 0)
        on = {(lzBlanked(d) ? 7'h00 : GLYPH[m_snap[d]]), m_dp[d]};
    end
    return (AL != 0) ? ~on : on;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 1'b0;
      m_pos  = 0;
      e_ctrl = 4'hF;
      e_val  = 8'hFF;
      e_fd   = 1'b0;
    end else begin
      e_ctrl = modelCtrl();
      e_val  = modelVal();
      e_fd   = m_run && enable && (m_pos == FRAME - 1);
      if (!enable) begin
        m_run = 1'b0;
        m_pos = 0;
      end else begin
        if (m_run) m_pos = m_pos + 1;
        if (!m_run || m_pos == FRAME) begin
          m_run = 1'b1;
          m_pos = 0;
          for (int j = 0; j < ND; j++) m_snap[j] = digits[4*j +: 4];
          m_dp = dp_mask;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      checkOutput("control", 32'(sevenseg_control), 32'(e_ctrl));
      checkOutput("value", 32'(sevenseg_value), 32'(e_val));
      checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
      if (frame_done) fd_seen++;
    end
  end

  initial begin
    int fd_before;
    int waited;
    $display("[TB] starting sevenseg_scan_driver bench");
    repeat (3) @(negedge clk);
    checkOutput("reset_control", 32'(sevenseg_control), 32'h0000000F);
    checkOutput("reset_value", 32'(sevenseg_value), 32'h000000FF);
    checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Scan order and timing, then a mid-frame data change
    applyStimulus(16'h4321, 4'b0000, 4'd15, 1'b1);
    repeat (60) @(negedge clk);
    applyStimulus(16'hFFFF, 4'b0000, 4'd15, 1'b1);
    repeat (300) @(negedge clk);

    // frame_done must appear within one frame
    fd_before = fd_seen;
    waited = 0;
    while (fd_seen == fd_before && waited < FRAME + 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("frame_done_seen", 32'(fd_seen > fd_before), 32'h1);

    // PWM at low brightness
    applyStimulus(16'h4321, 4'b0101, 4'd15, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(16'h4321, 4'b0101, 4'd3, 1'b1);
    repeat (300) @(negedge clk);

    // Enable drop while digit 2 is shown, then restart
    applyStimulus(16'h4321, 4'b0101, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(16'h4321, 4'b0101, 4'd15, 1'b1);
    repeat (2 * (1 + BS) * SLOT + 5) @(negedge clk);
    applyStimulus(16'h4321, 4'b0101, 4'd15, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(16'h8765, 4'b1010, 4'd15, 1'b1);
    repeat (200) @(negedge clk);

    // Leading-zero pattern
    applyStimulus(16'h0050, 4'b1000, 4'd15, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(16'h0050, 4'b1000, 4'd15, 1'b1);
    repeat (FRAME + 10) @(negedge clk);

    // Randomised frames with random mid-frame updates
    for (int k = 0; k < 8; k++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat ($urandom_range(40, 200)) @(negedge clk);
      digits  = 16'($urandom);
      dp_mask = 4'($urandom);
      repeat ($urandom_range(40, 250)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a scan
    applyStimulus(16'h4321, 4'b1111, 4'd15, 1'b1);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_control", 32'(sevenseg_control), 32'h0000000F);
    checkOutput("async_reset_value", 32'(sevenseg_value), 32'h000000FF);
    checkOutput("async_reset_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 20) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
